ps2_frame_rx: RTL and testbench

Synchronous PS/2 keyboard frame receiver, placed directly upstream of the keycode-to-HID converter. It runs in the system clock domain and takes the raw PS/2 clock and data pins. It oversamples and deglitches both lines, then checks each 11-bit frame for start, parity and stop. It folds the E0 (extended) and F0 (release) prefix bytes into a single per-key event for the converter.

---
 rtl/ps2_frame_rx_if.sv | 13 +
 rtl/ps2_frame_rx.sv | 159 +++++++++++++++
 tb/tb_ps2_frame_rx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_frame_rx_if.sv
// rtl/ps2_frame_rx_if.sv - decoded PS/2 byte and key event bundle
interface ps2_frame_rx_if;
    logic       byte_vld;
    logic [7:0] byte_out;
    logic       key_vld;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_rel;
    logic       err;

    modport master (output byte_vld, byte_out, key_vld, key_code, key_ext, key_rel, err);
    modport slave  (input  byte_vld, byte_out, key_vld, key_code, key_ext, key_rel, err);
endinterface

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 frame receiver with E0/F0 prefix folding
// Optional odd-parity enforcement when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 10000
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ps2_clk,
    input  logic           ps2_dat,
    ps2_frame_rx_if.master ev
);
    localparam logic [7:0]  FILT_MAX = 8'(FILTER_LEN - 1);
    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Index 0 is the PS/2 clock line, index 1 the data line.
    logic [1:0]  sync1, sync2, filt;
    logic [7:0]  filt_cnt [2];
    logic        clk_f_d;
    logic        fall, dat;

    state_t      state, state_d;
    logic [2:0]  bit_cnt, bit_cnt_d;
    logic [7:0]  shift, shift_d;
    logic [15:0] to_cnt;
    logic        ext_pend, rel_pend;
    logic        accept, frame_err, timeout_hit, parity_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic par, par_d;
    assign parity_ok = ^{shift, par};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= 2'b11;
            sync2       <= 2'b11;
            filt        <= 2'b11;
            clk_f_d     <= 1'b1;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else begin
            sync1   <= {ps2_dat, ps2_clk};
            sync2   <= sync1;
            clk_f_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FILT_MAX) begin
                    filt[i]     <= ~filt[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign fall = clk_f_d & ~filt[0];
    assign dat  = filt[1];

    always_comb begin
        state_d     = state;
        bit_cnt_d   = bit_cnt;
        shift_d     = shift;
        accept      = 1'b0;
        frame_err   = 1'b0;
        timeout_hit = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d       = par;
`endif
        if (state != IDLE && !fall && to_cnt >= TO_LIM) begin
            timeout_hit = 1'b1;
            state_d     = IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d = {dat, shift[7:1]};
                    if (bit_cnt == 3'd7) state_d = PARITY;
                    else bit_cnt_d = bit_cnt + 3'd1;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d   = dat;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat && parity_ok) accept    = 1'b1;
                    else                  frame_err = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            to_cnt      <= '0;
            ext_pend    <= 1'b0;
            rel_pend    <= 1'b0;
            ev.byte_vld <= 1'b0;
            ev.byte_out <= '0;
            ev.key_vld  <= 1'b0;
            ev.key_code <= '0;
            ev.key_ext  <= 1'b0;
            ev.key_rel  <= 1'b0;
            ev.err      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par         <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            shift   <= shift_d;
`ifdef PS2_PARITY_CHECK_EN
            par     <= par_d;
`endif
            if (state == IDLE || fall) to_cnt <= '0;
            else if (to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;

            ev.byte_vld <= accept;
            ev.key_vld  <= 1'b0;
            ev.err      <= frame_err | timeout_hit;
            if (accept) begin
                ev.byte_out <= shift;
                if (shift == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shift == 8'hF0) begin
                    rel_pend <= 1'b1;
                end else begin
                    ev.key_vld  <= 1'b1;
                    ev.key_code <= shift;
                    ev.key_ext  <= ext_pend;
                    ev.key_rel  <= rel_pend;
                    ext_pend    <= 1'b0;
                    rel_pend    <= 1'b0;
                end
            end else if (frame_err || timeout_hit) begin
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb/tb_ps2_frame_rx.sv - scoreboard bench for ps2_frame_rx
`timescale 1ns/1ps
module tb_ps2_frame_rx;
    localparam int FL = 8;
    localparam int TO = 300;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_frame_rx_if bus();

    ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .ev      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_byte [$];
    logic [9:0] exp_key  [$];
    int exp_err = 0;
    bit m_ext = 1'b0;
    bit m_rel = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: a frame is accepted when stop=1 (and total ones over data+parity odd
    // when parity is enforced); prefixes accumulate until a non-prefix byte.
    task automatic model_frame(logic [7:0] b, bit p, bit stop);
        bit ok;
        ok = stop;
`ifdef PS2_PARITY_CHECK_EN
        if ($countones({b, p}) % 2 == 0) ok = 1'b0;
`endif
        if (!ok) begin
            exp_err++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else begin
            exp_byte.push_back(b);
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_rel = 1'b1;
            else begin
                exp_key.push_back({m_ext, m_rel, b});
                m_ext = 1'b0;
                m_rel = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.byte_vld) begin
                check("err_with_byte", {31'd0, bus.err}, 32'd0);
                if (exp_byte.size() == 0) check("unexpected_byte", {24'd0, bus.byte_out}, 32'hFFFF);
                else check("byte_out", {24'd0, bus.byte_out}, {24'd0, exp_byte.pop_front()});
            end
            if (bus.key_vld) begin
                if (exp_key.size() == 0) check("unexpected_key", {22'd0, bus.key_ext, bus.key_rel, bus.key_code}, 32'hFFFF);
                else check("key_event", {22'd0, bus.key_ext, bus.key_rel, bus.key_code}, {22'd0, exp_key.pop_front()});
            end
            if (bus.err) begin
                check("err_expected", {31'd0, exp_err > 0}, 32'd1);
                if (exp_err > 0) exp_err--;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first n bits of a frame; glitch_bit >= 0 inverts data mid-high-phase on that bit.
    task automatic drive_bits(logic [7:0] b, bit p, bit stop, int n, int glitch_bit);
        logic [10:0] f;
        int hi, lo;
        f = {stop, p, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            hi = $urandom_range(40, FL + 1);
            lo = $urandom_range(40, FL + 1);
            ps2_dat = f[i];
            if (i == glitch_bit) begin
                cyc(5);
                ps2_dat = ~f[i];
                cyc(FL + 1);
                ps2_dat = f[i];
                cyc(26);
            end else begin
                cyc(hi);
            end
            ps2_clk = 1'b0;
            cyc(lo);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(logic [7:0] b, bit p, bit stop, int glitch_bit);
        model_frame(b, p, stop);
        drive_bits(b, p, stop, 11, glitch_bit);
        ps2_dat = 1'b1;
        cyc(3 * FL + 6);
    endtask

    task automatic send_good(logic [7:0] b);
        send_frame(b, ~(^b), 1'b1, -1);
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_byte_vld"}, {31'd0, bus.byte_vld}, 32'd0);
        check({tag, "_byte_out"}, {24'd0, bus.byte_out}, 32'd0);
        check({tag, "_key_vld"},  {31'd0, bus.key_vld},  32'd0);
        check({tag, "_key_code"}, {24'd0, bus.key_code}, 32'd0);
        check({tag, "_key_ext"},  {31'd0, bus.key_ext},  32'd0);
        check({tag, "_key_rel"},  {31'd0, bus.key_rel},  32'd0);
        check({tag, "_err"},      {31'd0, bus.err},      32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        bit rp, rs;
        int sel;

        cyc(3);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        cyc(5);

        send_good(8'h1C);
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        send_good(8'h75);

        send_frame(8'h1C, 1'b1, 1'b1, -1);
        send_frame(8'h5A, ~(^8'h5A), 1'b0, -1);

        exp_err++;
        m_ext = 1'b0;
        m_rel = 1'b0;
        drive_bits(8'h23, ~(^8'h23), 1'b1, 4, -1);
        ps2_dat = 1'b1;
        cyc(TO + 10 + 2 * FL);
        send_good(8'h23);

        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        cyc(FL - 2);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        cyc(3 * FL);
        send_good(8'h1C);
        send_frame(8'h3B, ~(^8'h3B), 1'b1, 4);

        send_good(8'hE0);
        drive_bits(8'h29, ~(^8'h29), 1'b1, 6, -1);
        reset_n = 1'b0;
        m_ext = 1'b0;
        m_rel = 1'b0;
        #1;
        check_outputs_zero("midreset");
        cyc(3);
        reset_n = 1'b1;
        ps2_dat = 1'b1;
        cyc(3 * FL);
        send_good(8'h29);

        for (int n = 0; n < 25; n++) begin
            sel = $urandom_range(9, 0);
            rb  = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
            rp  = ~(^rb);
            if ($urandom_range(9, 0) == 0) rp = ~rp;
            rs  = ($urandom_range(19, 0) != 0);
            send_frame(rb, rp, rs, -1);
        end

        cyc(200);
        check("bytes_pending", exp_byte.size(), 32'd0);
        check("keys_pending",  exp_key.size(),  32'd0);
        check("errs_pending",  exp_err,         32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
